// File: rtl/gemm_tile_ctrl_pkg.sv
// Shared types, default widths and tile-address arithmetic for the GEMM tile sequencer.
package gemm_ctrl_pkg;

    localparam int unsigned SIZE_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned MEM_LAT_DEF = 1;
    localparam int unsigned FLUSH_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_FLUSH,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Row-major tile address; callers truncate to their address width.
    function automatic logic [31:0] tile_addr(input logic [31:0] row,
                                              input logic [31:0] stride,
                                              input logic [31:0] col);
        return row * stride + col;
    endfunction

endpackage

// File: rtl/gemm_tile_ctrl_if.sv
// Handshake and address bundle between the tile sequencer and its host/PE/writeback side.
interface gemm_tile_ctrl_if
    import gemm_ctrl_pkg::*;
#(
    parameter int unsigned SizeWidth = SIZE_W_DEF,
    parameter int unsigned AddrWidth = ADDR_W_DEF
);
    logic                 start_i;
    logic [SizeWidth-1:0] m_size_i;
    logic [SizeWidth-1:0] k_size_i;
    logic [SizeWidth-1:0] n_size_i;
    logic [AddrWidth-1:0] a_addr_o;
    logic [AddrWidth-1:0] b_addr_o;
    logic                 rd_en_o;
    logic                 a_valid_o;
    logic                 b_valid_o;
    logic                 init_save_o;
    logic                 acc_clr_o;
    logic [AddrWidth-1:0] c_addr_o;
    logic                 c_valid_o;
    logic                 c_ready_i;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        input  start_i, m_size_i, k_size_i, n_size_i, c_ready_i,
        output a_addr_o, b_addr_o, rd_en_o, a_valid_o, b_valid_o, init_save_o,
               acc_clr_o, c_addr_o, c_valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, m_size_i, k_size_i, n_size_i, c_ready_i,
        input  a_addr_o, b_addr_o, rd_en_o, a_valid_o, b_valid_o, init_save_o,
               acc_clr_o, c_addr_o, c_valid_o, busy_o, done_o
    );

endinterface

// File: rtl/gemm_tile_ctrl_valid_delay.sv
// Depth-stage shift register carrying {valid, init} from read issue to the PE inputs.
module gemm_valid_delay
    import gemm_ctrl_pkg::*;
#(
    parameter int unsigned Depth = MEM_LAT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_valid,
    input  logic i_init,
    output logic o_valid,
    output logic o_init
);
    logic [Depth-1:0] r_valid_sr;
    logic [Depth-1:0] r_init_sr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_sr <= '0;
            r_init_sr  <= '0;
        end else begin
            r_valid_sr[0] <= i_valid;
            // init only travels with a valid beat so it can never surface alone
            r_init_sr[0]  <= i_init && i_valid;
            for (int i = 1; i < int'(Depth); i++) begin
                r_valid_sr[i] <= r_valid_sr[i-1];
                r_init_sr[i]  <= r_init_sr[i-1];
            end
        end
    end

    assign o_valid = r_valid_sr[Depth-1];
    assign o_init  = r_init_sr[Depth-1];

endmodule

// File: rtl/gemm_tile_ctrl.sv
// GEMM output-tile sequencer: walks m/n tiles, issues k-step A/B reads,
// aligns PE strobes through a latency-matched delay line and hands C tiles off.
module gemm_tile_ctrl
    import gemm_ctrl_pkg::*;
#(
    parameter int unsigned SizeWidth  = SIZE_W_DEF,
    parameter int unsigned AddrWidth  = ADDR_W_DEF,
    parameter int unsigned MemLatency = MEM_LAT_DEF
) (
    input logic              clk_i,
    input logic              rst_i,
    gemm_tile_ctrl_if.master bus
);
    // state | meaning
    // IDLE  | waiting for start_i
    // CALC  | one A/B read per k step of the current tile
    // FLUSH | MemLatency+1 cycles: delay-line drain plus PE register update
    // WRITE | C tile offered to writeback until c_ready_i
    // DONE  | last tile accepted; done_o follows next cycle

    state_e                 r_state, w_state_nxt;
    logic [SizeWidth-1:0]   r_m_size, r_k_size, r_n_size;
    logic [SizeWidth-1:0]   w_m_size_nxt, w_k_size_nxt, w_n_size_nxt;
    logic [SizeWidth-1:0]   r_m, r_n, r_k;
    logic [SizeWidth-1:0]   w_m_nxt, w_n_nxt, w_k_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt, w_flush_nxt;
    logic                   r_acc_clr, r_done;
    logic                   w_rd_en, w_init_issue, w_handshake, w_sizes_zero;
    logic                   w_last_k, w_last_n, w_last_m;
    logic                   w_pe_valid, w_pe_init;

    assign w_last_k     = (r_k == r_k_size - SizeWidth'(1));
    assign w_last_n     = (r_n == r_n_size - SizeWidth'(1));
    assign w_last_m     = (r_m == r_m_size - SizeWidth'(1));
    assign w_sizes_zero = (bus.m_size_i == '0) || (bus.k_size_i == '0) || (bus.n_size_i == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_m_size    <= '0;
            r_k_size    <= '0;
            r_n_size    <= '0;
            r_m         <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_flush_cnt <= '0;
            r_acc_clr   <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_m_size    <= w_m_size_nxt;
            r_k_size    <= w_k_size_nxt;
            r_n_size    <= w_n_size_nxt;
            r_m         <= w_m_nxt;
            r_n         <= w_n_nxt;
            r_k         <= w_k_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_acc_clr   <= w_handshake;
            r_done      <= (r_state == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_m_size_nxt = r_m_size;
        w_k_size_nxt = r_k_size;
        w_n_size_nxt = r_n_size;
        w_m_nxt      = r_m;
        w_n_nxt      = r_n;
        w_k_nxt      = r_k;
        w_flush_nxt  = r_flush_cnt;
        w_rd_en      = 1'b0;
        w_handshake  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_m_size_nxt = bus.m_size_i;
                    w_k_size_nxt = bus.k_size_i;
                    w_n_size_nxt = bus.n_size_i;
                    w_m_nxt      = '0;
                    w_n_nxt      = '0;
                    w_k_nxt      = '0;
                    w_state_nxt  = w_sizes_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_rd_en = 1'b1;
                w_k_nxt = r_k + SizeWidth'(1);
                if (w_last_k) begin
                    w_state_nxt = ST_FLUSH;
                    w_flush_nxt = FLUSH_CNT_W'(MemLatency);
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) w_state_nxt = ST_WRITE;
                else                   w_flush_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
            end
            ST_WRITE: begin
                if (bus.c_ready_i) begin
                    w_handshake = 1'b1;
                    w_k_nxt     = '0;
                    if (!w_last_n) begin
                        w_n_nxt     = r_n + SizeWidth'(1);
                        w_state_nxt = ST_CALC;
                    end else if (!w_last_m) begin
                        w_m_nxt     = r_m + SizeWidth'(1);
                        w_n_nxt     = '0;
                        w_state_nxt = ST_CALC;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_init_issue = w_rd_en && (r_k == '0);

    gemm_valid_delay #(.Depth(MemLatency)) u_valid_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (w_rd_en),
        .i_init  (w_init_issue),
        .o_valid (w_pe_valid),
        .o_init  (w_pe_init)
    );

    assign bus.rd_en_o     = w_rd_en;
    assign bus.a_addr_o    = (r_state == ST_CALC)
                             ? AddrWidth'(tile_addr(32'(r_m), 32'(r_k_size), 32'(r_k))) : '0;
    assign bus.b_addr_o    = (r_state == ST_CALC)
                             ? AddrWidth'(tile_addr(32'(r_k), 32'(r_n_size), 32'(r_n))) : '0;
    assign bus.c_addr_o    = (r_state == ST_WRITE)
                             ? AddrWidth'(tile_addr(32'(r_m), 32'(r_n_size), 32'(r_n))) : '0;
    assign bus.c_valid_o   = (r_state == ST_WRITE);
    assign bus.a_valid_o   = w_pe_valid;
    assign bus.b_valid_o   = w_pe_valid;
    assign bus.init_save_o = w_pe_init;
    assign bus.acc_clr_o   = r_acc_clr;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.done_o      = r_done;

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Directed bench for gemm_tile_ctrl: size table with address scoreboard plus
// reset, backpressure and PE-alignment sequences.
module tb_gemm_tile_ctrl;
    import gemm_ctrl_pkg::*;

    localparam int unsigned SW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned ML = 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    gemm_tile_ctrl_if #(.SizeWidth(SW), .AddrWidth(AW)) bus ();

    gemm_tile_ctrl #(.SizeWidth(SW), .AddrWidth(AW), .MemLatency(ML)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    // Minimal MAC PE with 4 all-ones products per valid beat.
    int pe_acc = 0;
    always @(posedge clk_i) begin
        if (bus.acc_clr_o)      pe_acc <= 0;
        else if (bus.a_valid_o) pe_acc <= bus.init_save_o ? 4 : pe_acc + 4;
    end

    typedef struct {
        int m, k, n;
        int exp_done;
        int exp_reads;
        int exp_writes;
        int exp_first_c;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input int m, input int k, input int n,
                           output int done_cyc, output int reads, output int writes,
                           output int valids, output int inits, output int clrs,
                           output int first_c, output int c_val);
        int aq[$];
        int bq[$];
        int cq[$];
        int vin_tile;
        for (int mi = 0; mi < m; mi++) begin
            for (int ni = 0; ni < n; ni++) begin
                for (int ki = 0; ki < k; ki++) begin
                    aq.push_back(mi * k + ki);
                    bq.push_back(ki * n + ni);
                end
                if (k > 0) cq.push_back(mi * n + ni);
            end
        end
        done_cyc = -1; reads = 0; writes = 0; valids = 0; inits = 0; clrs = 0;
        first_c = -1; c_val = -1; vin_tile = 0;
        bus.m_size_i = SW'(m);
        bus.k_size_i = SW'(k);
        bus.n_size_i = SW'(n);
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc == 1) check("busy_after_start", bus.busy_o, 1);
            if (bus.rd_en_o) begin
                reads++;
                if (aq.size() == 0) check("extra_read", 1, 0);
                else begin
                    check("a_addr", bus.a_addr_o, aq.pop_front());
                    check("b_addr", bus.b_addr_o, bq.pop_front());
                end
            end
            if (bus.a_valid_o) begin
                valids++;
                check("b_valid", bus.b_valid_o, 1);
                check("init_save_pos", bus.init_save_o, (vin_tile == 0) ? 1 : 0);
                if (bus.init_save_o) inits++;
                vin_tile++;
            end else if (bus.init_save_o) begin
                check("init_alone", 1, 0);
            end
            if (bus.acc_clr_o) clrs++;
            if (bus.c_valid_o) begin
                writes++;
                if (first_c < 0) first_c = cyc;
                c_val    = pe_acc;
                vin_tile = 0;
                if (cq.size() == 0) check("extra_write", 1, 0);
                else check("c_addr", bus.c_addr_o, cq.pop_front());
            end
            if (bus.done_o) begin
                done_cyc = cyc;
                check("busy_at_done", bus.busy_o, 0);
                break;
            end
            tick();
        end
        if (done_cyc < 0) check("done_seen", 0, 1);
        check("reads_left", aq.size(), 0);
        check("writes_left", cq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   bus.rd_en_o, 0);
        check({tag, "_a_addr"},  bus.a_addr_o, 0);
        check({tag, "_b_addr"},  bus.b_addr_o, 0);
        check({tag, "_a_valid"}, bus.a_valid_o, 0);
        check({tag, "_b_valid"}, bus.b_valid_o, 0);
        check({tag, "_init"},    bus.init_save_o, 0);
        check({tag, "_c_valid"}, bus.c_valid_o, 0);
        check({tag, "_c_addr"},  bus.c_addr_o, 0);
        check({tag, "_busy"},    bus.busy_o, 0);
        check({tag, "_done"},    bus.done_o, 0);
        check({tag, "_acc_clr"}, bus.acc_clr_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d, r, w, v, ini, cl, fc, cv, stable, seen;

        vecs[0] = '{m: 1, k: 4, n: 1, exp_done: 9,  exp_reads: 4,  exp_writes: 1, exp_first_c: 7};
        vecs[1] = '{m: 2, k: 3, n: 2, exp_done: 26, exp_reads: 12, exp_writes: 4, exp_first_c: 6};
        vecs[2] = '{m: 1, k: 1, n: 1, exp_done: 6,  exp_reads: 1,  exp_writes: 1, exp_first_c: 4};
        vecs[3] = '{m: 3, k: 2, n: 1, exp_done: 17, exp_reads: 6,  exp_writes: 3, exp_first_c: 5};
        vecs[4] = '{m: 1, k: 2, n: 3, exp_done: 17, exp_reads: 6,  exp_writes: 3, exp_first_c: 5};
        vecs[5] = '{m: 2, k: 0, n: 2, exp_done: 2,  exp_reads: 0,  exp_writes: 0, exp_first_c: -1};
        vecs[6] = '{m: 0, k: 3, n: 1, exp_done: 2,  exp_reads: 0,  exp_writes: 0, exp_first_c: -1};

        bus.start_i   = 1'b0;
        bus.m_size_i  = '0;
        bus.k_size_i  = '0;
        bus.n_size_i  = '0;
        bus.c_ready_i = 1'b1;

        // reset state and acc_clr release behaviour
        tick();
        tick();
        check_reset_outputs("rst");
        rst_i = 1'b0;
        #1;
        check("acc_clr_after_release", bus.acc_clr_o, 1);
        tick();
        check("acc_clr_second_cycle", bus.acc_clr_o, 0);

        // table of sizes with c_ready held high
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i].m, vecs[i].k, vecs[i].n, d, r, w, v, ini, cl, fc, cv);
            check($sformatf("v%0d_done_cycle", i), d, vecs[i].exp_done);
            check($sformatf("v%0d_reads", i), r, vecs[i].exp_reads);
            check($sformatf("v%0d_valids", i), v, vecs[i].exp_reads);
            check($sformatf("v%0d_writes", i), w, vecs[i].exp_writes);
            check($sformatf("v%0d_inits", i), ini, vecs[i].exp_writes);
            check($sformatf("v%0d_acc_clr", i), cl, vecs[i].exp_writes);
            check($sformatf("v%0d_first_c", i), fc, vecs[i].exp_first_c);
            tick();
        end

        // backpressure: c_ready low for 5 cycles on a 1x1x1 job
        bus.c_ready_i = 1'b0;
        bus.m_size_i  = SW'(1);
        bus.k_size_i  = SW'(1);
        bus.n_size_i  = SW'(1);
        bus.start_i   = 1'b1;
        tick();
        bus.start_i   = 1'b0;
        seen = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (bus.c_valid_o) begin
                seen = cyc;
                break;
            end
            tick();
        end
        check("bp_c_valid_rise", seen, 4);
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.c_valid_o && bus.c_addr_o == '0) stable++;
            check("bp_no_read", bus.rd_en_o, 0);
            check("bp_no_done", bus.done_o, 0);
            tick();
        end
        bus.c_ready_i = 1'b1;
        #1;
        if (bus.c_valid_o && bus.c_addr_o == '0) stable++;
        check("bp_stable_cycles", stable, 6);
        tick();
        check("bp_acc_clr", bus.acc_clr_o, 1);
        check("bp_c_valid_drop", bus.c_valid_o, 0);
        check("bp_done_early", bus.done_o, 0);
        tick();
        check("bp_done", bus.done_o, 1);
        tick();

        // reset asserted mid-operation on a 2x2x2 job
        bus.m_size_i = SW'(2);
        bus.k_size_i = SW'(2);
        bus.n_size_i = SW'(2);
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        tick();
        tick();
        check("mid_a_valid_before_rst", bus.a_valid_o, 1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        tick();
        check("mid_rst_hold_valid", bus.a_valid_o, 0);
        check("mid_rst_hold_clr", bus.acc_clr_o, 1);
        rst_i = 1'b0;
        #1;
        check("mid_rst_release_clr", bus.acc_clr_o, 1);
        check("mid_rst_release_busy", bus.busy_o, 0);
        tick();
        check("mid_rst_clr_drop", bus.acc_clr_o, 0);
        run_vec(2, 2, 2, d, r, w, v, ini, cl, fc, cv);
        check("restart_done_cycle", d, 22);
        check("restart_reads", r, 8);
        check("restart_writes", w, 4);
        check("restart_first_c", fc, 5);
        tick();

        // PE pairing: 1x3x1 on all-ones operands, 4 products per beat
        run_vec(1, 3, 1, d, r, w, v, ini, cl, fc, cv);
        check("pe_c_value", cv, 12);
        check("pe_writes", w, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gemm_tile_ctrl.md
Name: gemm_tile_ctrl

Overview:
- Sequencer for the output-stationary MAC PE array in the GEMM datapath.
- Walks the output tiles of C = A x B in tile units (m outer, n inner, k reduction).
- Issues A/B buffer read addresses and drives the PE array's valid, init_save and acc_clr strobes.
- Hands each finished C tile to the writeback path with a valid/ready handshake.

Parameters:
- SizeWidth, 8, width of the M/K/N tile-count inputs
- AddrWidth, 16, width of the A/B/C tile addresses
- MemLatency, 1, cycles from address issue to operand data at the PE inputs (1..4)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- start_i  in  1  start pulse; sizes sampled this cycle
- m_size_i  in  SizeWidth  M in tiles
- k_size_i  in  SizeWidth  K in tiles
- n_size_i  in  SizeWidth  N in tiles
- a_addr_o  out  AddrWidth  A tile read address
- b_addr_o  out  AddrWidth  B tile read address
- rd_en_o  out  1  A/B read strobe
- a_valid_o  out  1  PE a_valid
- b_valid_o  out  1  PE b_valid (identical to a_valid_o)
- init_save_o  out  1  PE init_save (first k step of a tile)
- acc_clr_o  out  1  PE accumulator clear
- c_addr_o  out  AddrWidth  C tile address for writeback
- c_valid_o  out  1  C tile result valid
- c_ready_i  in  1  writeback accepts C
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse at completion

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst_i high, any time including mid-operation):
  - FSM returns to IDLE; all counters are zero.
  - All outputs are 0 except acc_clr_o, which is 1 during reset and for the first cycle after release.
  - Any in-flight delay-line entries are discarded.
- States: IDLE, CALC, FLUSH, WRITE, DONE.
- IDLE:
  - start_i latches the three sizes and zeroes m, n, k.
  - If any size is 0, go to DONE; otherwise go to CALC.
  - start_i is ignored outside IDLE.
- CALC:
  - One cycle per k step: rd_en_o=1, a_addr_o = m*K + k, b_addr_o = k*N + n.
  - k increments each cycle.
  - The cycle issuing k = K-1 moves to FLUSH.
- Valid/init alignment:
  - rd_en_o delayed by MemLatency cycles drives a_valid_o and b_valid_o.
  - (rd_en_o && k==0) delayed by MemLatency cycles drives init_save_o.
  - init_save_o is always asserted together with a_valid_o, never alone.
- FLUSH:
  - Lasts MemLatency+1 cycles: delay-line drain plus one cycle for the PE register update.
  - Then go to WRITE.
- WRITE:
  - c_valid_o=1, c_addr_o = m*N + n.
  - c_valid_o and c_addr_o hold stable until c_ready_i is sampled high.
- On the WRITE handshake:
  - acc_clr_o pulses the next cycle.
  - If n < N-1: n++, k=0, go to CALC.
  - Else if m < M-1: m++, n=0, k=0, go to CALC.
  - Else go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o = (state != IDLE).
- Latency: a tile with K steps occupies K + MemLatency + 1 cycles before c_valid_o rises.
- Total cycles ≈ M*N*(K + MemLatency + 2) plus writeback stalls.
- Arithmetic:
  - Address products and sums are computed at AddrWidth and truncate (wrap) silently.
  - The caller guarantees M*K, K*N and M*N each fit in AddrWidth.
- Boundaries:
  - K=1: CALC lasts one cycle; init_save_o fires on the only valid cycle.
  - M=N=1: exactly one WRITE.
  - c_ready_i held high: no stall cycles.
  - c_ready_i low indefinitely: the block holds in WRITE with no further reads.

Decomposition:
- Package gemm_ctrl_pkg holds:
  - state enum type
  - default widths
  - helper functions for the address computations
- One sub-module: gemm_valid_delay, a MemLatency-deep shift register carrying {valid, init}, cleared by rst_i.

Test Plan:
- Reset mid-CALC (M=K=N=2, assert rst_i at cycle 3) -> outputs return to 0 with acc_clr_o=1; after release, start_i restarts cleanly from m=n=k=0.
- M=1, K=4, N=1, MemLatency=1, c_ready_i=1 -> a_addr_o 0,1,2,3 and b_addr_o 0,1,2,3; init_save_o on the first valid cycle only; a_valid_o high for 4 cycles; c_valid_o at start+7 with c_addr_o=0; done_o 2 cycles later.
- M=2, K=3, N=2 with c_ready_i tied high -> four WRITEs with c_addr_o 0,1,2,3; second tile's b_addr_o = 1,3,5; acc_clr_o pulses after each handshake.
- Backpressure: M=N=K=1, c_ready_i low for 5 cycles -> c_valid_o and c_addr_o stay stable for 6 cycles; no rd_en_o during the stall; done_o only after the handshake.
- K=0 -> done_o pulses 2 cycles after start_i; rd_en_o and c_valid_o never assert.
- Paired with the MAC PE (NumInputs=4) on all-ones operands, M=N=1, K=3 -> written C = 12, confirming init_save alignment without stale accumulation.
